binary_to_bcd_converter: RTL and testbench

Sequential binary-to-BCD converter that sits directly upstream of the six-digit seven-segment tube interface. It takes a 20-bit unsigned binary value and produces the 24-bit packed BCD word (six 4-bit digits, most-significant digit in bits [23:20]) that drives the interface's `Number_Sig` input. The conversion uses an iterative shift-and-add-3 (double-dabble) loop, one bit per clock, with a start/done handshake. The last result is held stable so the display never shows intermediate values.

---
 rtl/binary_to_bcd_converter_pkg.sv | 14 +
 rtl/binary_to_bcd_converter_if.sv | 21 ++
 rtl/binary_to_bcd_converter_digit_adj.sv | 10 +
 rtl/binary_to_bcd_converter.sv | 92 +++++++++
 tb/tb_binary_to_bcd_converter.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/binary_to_bcd_converter_pkg.sv
// Shared constants and state encoding for the binary-to-BCD converter.
package bcd_pkg;
  localparam int unsigned BIN_W  = 20;
  localparam int unsigned DIGITS = 6;
  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned CNT_W  = 5;
  localparam logic [BIN_W-1:0] MAX_VAL = 20'hF423F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/binary_to_bcd_converter_if.sv
// Start/done handshake and data bundle between the requester and the converter.
interface binary_to_bcd_converter_if;
  import bcd_pkg::*;

  logic [BIN_W-1:0] Bin_Data;
  logic             Start_Sig;
  logic [BCD_W-1:0] BCD_Data;
  logic             Busy_Sig;
  logic             Done_Sig;
  logic             Ovf_Sig;

  modport master (
    output Bin_Data, Start_Sig,
    input  BCD_Data, Busy_Sig, Done_Sig, Ovf_Sig
  );

  modport slave (
    input  Bin_Data, Start_Sig,
    output BCD_Data, Busy_Sig, Done_Sig, Ovf_Sig
  );
endinterface

// File: rtl/binary_to_bcd_converter_digit_adj.sv
// Double-dabble digit correction: digits of 5 or more get 3 added before the shift.
module bcd_digit_adj (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) digit_o = digit_i + 4'd3;
  end
endmodule

// File: rtl/binary_to_bcd_converter.sv
// Iterative 20-bit binary to 6-digit packed BCD converter, one bit per clock,
// with saturation at 999999 and a result register held between conversions.
module binary_to_bcd_converter
  import bcd_pkg::*;
(
  input  logic                       CLK,
  input  logic                       RST_N,
  binary_to_bcd_converter_if.slave   bus
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] op_q, op_d;
  logic [BCD_W-1:0] bcd_q, bcd_d, bcd_adj;
  logic [BCD_W-1:0] bcd_data_q, bcd_data_d;
  logic             ovf_flag_q, ovf_flag_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (bcd_q[g*4 +: 4]),
      .digit_o (bcd_adj[g*4 +: 4])
    );
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    bcd_d      = bcd_q;
    bcd_data_d = bcd_data_q;
    ovf_flag_d = ovf_flag_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.Start_Sig) begin
          if (bus.Bin_Data > MAX_VAL) begin
            op_d       = MAX_VAL;
            ovf_flag_d = 1'b1;
          end else begin
            op_d       = bus.Bin_Data;
            ovf_flag_d = 1'b0;
          end
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Operand MSB shifts into the least-significant BCD bit.
        {bcd_d, op_d} = {bcd_adj, op_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(BIN_W - 1)) state_d = DONE;
      end
      DONE: begin
        bcd_data_d = bcd_q;
        ovf_d      = ovf_flag_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      bcd_q      <= '0;
      bcd_data_q <= '0;
      ovf_flag_q <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      bcd_q      <= bcd_d;
      bcd_data_q <= bcd_data_d;
      ovf_flag_q <= ovf_flag_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign bus.BCD_Data = bcd_data_q;
  assign bus.Busy_Sig = (state_q != IDLE);
  assign bus.Done_Sig = done_q;
  assign bus.Ovf_Sig  = ovf_q;
endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// Self-checking bench: a cycle-level decimal model checked every cycle, plus directed literal checks.
module tb_binary_to_bcd_converter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   chk_en;

  binary_to_bcd_converter_if bus ();

  binary_to_bcd_converter dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int unsigned v);
    logic [23:0]  r;
    int unsigned  x;
    x = (v > 999999) ? 999999 : v;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted request completes 21 edges later; the held result is the decimal value.
  int unsigned pend_val;
  int          remain;
  logic [23:0] exp_bcd;
  logic        exp_ovf;
  logic        exp_done;

  initial begin
    remain = 0; exp_bcd = '0; exp_ovf = 1'b0; exp_done = 1'b0; pend_val = 0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      remain = 0; exp_bcd = '0; exp_ovf = 1'b0; exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (remain > 0) begin
        remain = remain - 1;
        if (remain == 0) begin
          exp_bcd  = to_bcd(pend_val);
          exp_ovf  = (pend_val > 999999);
          exp_done = 1'b1;
        end
      end else if (bus.Start_Sig) begin
        pend_val = int'(bus.Bin_Data);
        remain   = 21;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_bcd",  32'(bus.BCD_Data), 32'(exp_bcd));
      chk("model_busy", 32'(bus.Busy_Sig), 32'(remain > 0));
      chk("model_done", 32'(bus.Done_Sig), 32'(exp_done));
      chk("model_ovf",  32'(bus.Ovf_Sig),  32'(exp_ovf));
    end
  end

  task automatic wait_done(output int cyc, output int busy_n);
    cyc = 0;
    busy_n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.Done_Sig) return;
      busy_n += int'(bus.Busy_Sig);
    end
    chk("done_timeout", 32'(cyc), 32'd0);
  endtask

  // Drive a single-cycle Start; returns at the negedge right after the accepting edge.
  task automatic pulse_start(input logic [19:0] val);
    bus.Bin_Data  = val;
    bus.Start_Sig = 1'b1;
    @(negedge clk);
    bus.Start_Sig = 1'b0;
  endtask

  task automatic count_dones(input int n, output int dones);
    dones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dones += int'(bus.Done_Sig);
    end
  endtask

  task automatic conv(input string name, input logic [19:0] val,
                      input logic [23:0] bcd_lit, input logic ovf_lit);
    int cyc, busy_n, b0;
    pulse_start(val);
    b0 = int'(bus.Busy_Sig);
    wait_done(cyc, busy_n);
    chk({name, "_lat"},  32'(cyc), 32'd21);
    chk({name, "_bcd"},  32'(bus.BCD_Data), 32'(bcd_lit));
    chk({name, "_ovf"},  32'(bus.Ovf_Sig), 32'(ovf_lit));
    chk({name, "_busy"}, 32'(b0 + busy_n), 32'd21);
  endtask

  initial begin
    int cyc, busy_n, dones;
    checks = 0; errors = 0; chk_en = 1'b0;
    rst_n = 1'b0;
    bus.Start_Sig = 1'b0;
    bus.Bin_Data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_bcd",  32'(bus.BCD_Data), 32'h0);
    chk("rst_busy", 32'(bus.Busy_Sig), 32'h0);
    chk("rst_done", 32'(bus.Done_Sig), 32'h0);
    chk("rst_ovf",  32'(bus.Ovf_Sig),  32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    chk("model_pin_123456",  32'(to_bcd(123456)),  32'h123456);
    chk("model_pin_1048575", 32'(to_bcd(1048575)), 32'h999999);

    @(negedge clk);
    conv("zero",   20'd0,       24'h000000, 1'b0);
    conv("v123456", 20'h1E240,  24'h123456, 1'b0);
    conv("v999999", 20'd999999, 24'h999999, 1'b0);
    conv("vmax",   20'd1048575, 24'h999999, 1'b1);
    conv("v1",     20'd1,       24'h000001, 1'b0);

    // Second Start during a conversion is dropped.
    pulse_start(20'd42);
    repeat (4) @(negedge clk);
    pulse_start(20'd77);
    wait_done(cyc, busy_n);
    chk("ignore_lat", 32'(cyc), 32'd16);
    chk("ignore_bcd", 32'(bus.BCD_Data), 32'h000042);
    count_dones(30, dones);
    chk("ignore_single_done", 32'(dones), 32'd0);

    // Reset in the middle of a conversion aborts it.
    pulse_start(20'd654321);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_bcd",  32'(bus.BCD_Data), 32'h0);
    chk("abort_busy", 32'(bus.Busy_Sig), 32'h0);
    count_dones(30, dones);
    chk("abort_no_done", 32'(dones), 32'd0);
    conv("v654321", 20'd654321, 24'h654321, 1'b0);

    // Start held high: back-to-back conversions every 22 cycles.
    bus.Bin_Data  = 20'd9;
    bus.Start_Sig = 1'b1;
    @(negedge clk);
    bus.Bin_Data = 20'd10;
    wait_done(cyc, busy_n);
    chk("b2b_first_lat", 32'(cyc), 32'd21);
    chk("b2b_first_bcd", 32'(bus.BCD_Data), 32'h000009);
    wait_done(cyc, busy_n);
    bus.Start_Sig = 1'b0;
    chk("b2b_gap", 32'(cyc), 32'd22);
    chk("b2b_second_bcd", 32'(bus.BCD_Data), 32'h000010);
    count_dones(30, dones);
    chk("b2b_stop", 32'(dones), 32'd0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
